// File: rtl/fc_hwpe_cfg_bridge.sv
// fc_hwpe_cfg_bridge: APB3 slave to HWPE peripheral (req/gnt/r_valid) bridge.
// One access in flight at a time, tagged with a rolling ID; stale responses
// are dropped. Optional watchdog enabled by defining FC_HWPE_CFG_TIMEOUT_EN.
module fc_hwpe_cfg_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      per_req_o,
    output logic [PER_ADDR_WIDTH-1:0] per_add_o,
    output logic                      per_wen_o,
    output logic [DATA_WIDTH/8-1:0]   per_be_o,
    output logic [DATA_WIDTH-1:0]     per_data_o,
    output logic [ID_WIDTH-1:0]       per_id_o,
    input  logic                      per_gnt_i,
    input  logic                      per_r_valid_i,
    input  logic [DATA_WIDTH-1:0]     per_r_data_i,
    input  logic [ID_WIDTH-1:0]       per_r_id_i,
    input  logic                      acc_busy_i,
    output logic                      busy_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                    state, state_nxt;
    logic [PER_ADDR_WIDTH-1:0] add_q, add_nxt;
    logic [DATA_WIDTH-1:0]     data_q, data_nxt;
    logic                      wen_q, wen_nxt;
    logic [ID_WIDTH-1:0]       id_q, id_nxt;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_nxt;
    logic                      req_q, pready_q, busy_q;
    logic                      expired_c;

`ifdef FC_HWPE_CFG_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q, err_nxt;

    assign expired_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every state change, counts while REQ/WAIT persist
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if ((state_nxt != state) || !(state inside {REQ, WAIT})) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pslverr_o = err_q;
`else
    assign expired_c = 1'b0;
    assign pslverr_o = 1'b0;
`endif

    // State and payload registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            add_q    <= '0;
            data_q   <= '0;
            wen_q    <= 1'b1;
            id_q     <= '0;
            prdata_q <= '0;
            req_q    <= 1'b0;
            pready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            add_q    <= add_nxt;
            data_q   <= data_nxt;
            wen_q    <= wen_nxt;
            id_q     <= id_nxt;
            prdata_q <= prdata_nxt;
            req_q    <= (state_nxt == REQ);
            pready_q <= (state_nxt == RESP);
            busy_q   <= acc_busy_i | (state != IDLE);
        end
    end

    // Next-state, payload capture and response data selection
    always_comb begin
        state_nxt  = state;
        add_nxt    = add_q;
        data_nxt   = data_q;
        wen_nxt    = wen_q;
        id_nxt     = id_q;
        prdata_nxt = prdata_q;
`ifdef FC_HWPE_CFG_TIMEOUT_EN
        err_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (psel_i && penable_i) begin
                    state_nxt = REQ;
                    add_nxt   = PER_ADDR_WIDTH'(paddr_i);
                    data_nxt  = pwdata_i;
                    wen_nxt   = ~pwrite_i;
                end
            end
            REQ: begin
                // a grant in the expiry cycle still wins
                if (per_gnt_i) begin
                    state_nxt = WAIT;
                end else if (expired_c) begin
                    state_nxt  = RESP;
                    prdata_nxt = '1;
`ifdef FC_HWPE_CFG_TIMEOUT_EN
                    err_nxt    = 1'b1;
`endif
                end
            end
            WAIT: begin
                if (per_r_valid_i && (per_r_id_i == id_q)) begin
                    state_nxt  = RESP;
                    prdata_nxt = wen_q ? per_r_data_i : '0;
                end else if (expired_c) begin
                    state_nxt  = RESP;
                    prdata_nxt = '1;
`ifdef FC_HWPE_CFG_TIMEOUT_EN
                    err_nxt    = 1'b1;
`endif
                end
            end
            RESP: begin
                state_nxt = IDLE;
                id_nxt    = id_q + ID_WIDTH'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prdata_o   = prdata_q;
    assign pready_o   = pready_q;
    assign per_req_o  = req_q;
    assign per_add_o  = add_q;
    assign per_wen_o  = wen_q;
    assign per_be_o   = {BE_WIDTH{1'b1}};
    assign per_data_o = data_q;
    assign per_id_o   = id_q;
    assign busy_o     = busy_q;

endmodule
